// File: rtl/board_anim_sequencer_if.sv
// Move-request handshake and animated display bus between the game controller and the board sequencer.
interface board_anim_sequencer_if;
  logic       game_clear;
  logic       move_req;
  logic       move_player;
  logic [3:0] move_target;
  logic       move_ack;
  logic       busy;
  logic [3:0] p1_disp;
  logic [3:0] p2_disp;
  logic       step_pulse;
  logic       turn_done;

  modport master (
    output game_clear, move_req, move_player, move_target,
    input  move_ack, busy, p1_disp, p2_disp, step_pulse, turn_done
  );

  modport slave (
    input  game_clear, move_req, move_player, move_target,
    output move_ack, busy, p1_disp, p2_disp, step_pulse, turn_done
  );
endinterface

// File: rtl/board_anim_sequencer.sv
// Walks one player's displayed board position toward a requested tile, one tile per step period.
// Optional ANIM_BACKJUMP_EN: downward moves land on the target in a single step.
module board_anim_sequencer #(
  parameter int STEP_CYCLES   = 25_000_000,
  parameter int SETTLE_CYCLES = 50_000_000,
  parameter int MAX_POS       = 10
) (
  input logic clk,
  input logic reset,
  board_anim_sequencer_if.slave bus
);
  localparam int CMAX = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] STEP_TC   = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_TC = CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    MAXP      = 4'(MAX_POS);

  typedef enum logic [1:0] {S_IDLE, S_STEP_WAIT, S_SETTLE, S_DONE} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    p1, p1_d, p2, p2_d, tgt, tgt_d;
  logic          sel, sel_d, up, up_d;
  logic          ack_d, step_d, done_d, busy_d;
  logic [3:0]    cur, req_cur, req_tgt, nxt;

  assign cur     = sel ? p2 : p1;
  assign req_cur = bus.move_player ? p2 : p1;
  assign req_tgt = (bus.move_target > MAXP) ? MAXP : bus.move_target;

`ifdef ANIM_BACKJUMP_EN
  assign nxt = up ? cur + 4'd1 : tgt;
`else
  assign nxt = up ? cur + 4'd1 : cur - 4'd1;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    p1_d    = p1;
    p2_d    = p2;
    tgt_d   = tgt;
    sel_d   = sel;
    up_d    = up;
    ack_d   = 1'b0;
    step_d  = 1'b0;
    done_d  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.move_req) begin
          sel_d   = bus.move_player;
          tgt_d   = req_tgt;
          up_d    = req_tgt > req_cur;
          cnt_d   = '0;
          ack_d   = 1'b1;
          state_d = (req_tgt == req_cur) ? S_SETTLE : S_STEP_WAIT;
        end
      end
      S_STEP_WAIT: begin
        if (cnt == STEP_TC) begin
          cnt_d  = '0;
          step_d = 1'b1;
          if (sel) p2_d = nxt;
          else     p1_d = nxt;
          if (nxt == tgt) state_d = S_SETTLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt == SETTLE_TC) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // game_clear overrides the FSM, including a same-cycle accept
    if (bus.game_clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      p1_d    = '0;
      p2_d    = '0;
      ack_d   = 1'b0;
      step_d  = 1'b0;
      done_d  = 1'b0;
    end
    busy_d = (state != S_IDLE) && !bus.game_clear;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      p1             <= '0;
      p2             <= '0;
      tgt            <= '0;
      sel            <= 1'b0;
      up             <= 1'b0;
      bus.move_ack   <= 1'b0;
      bus.step_pulse <= 1'b0;
      bus.turn_done  <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      p1             <= p1_d;
      p2             <= p2_d;
      tgt            <= tgt_d;
      sel            <= sel_d;
      up             <= up_d;
      bus.move_ack   <= ack_d;
      bus.step_pulse <= step_d;
      bus.turn_done  <= done_d;
      bus.busy       <= busy_d;
    end
  end

  assign bus.p1_disp = p1;
  assign bus.p2_disp = p2;
endmodule

// File: tb/tb_board_anim_sequencer.sv
// Directed bench for board_anim_sequencer with STEP_CYCLES=4, SETTLE_CYCLES=3, MAX_POS=10.
module tb_board_anim_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   clear_at = -1;

  logic [3:0] p1_h [0:63];
  logic [3:0] p2_h [0:63];
  logic       sp_h [0:63];
  logic       td_h [0:63];
  logic       bz_h [0:63];
  logic       ak_h [0:63];

  board_anim_sequencer_if bus ();

  board_anim_sequencer #(.STEP_CYCLES(4), .SETTLE_CYCLES(3), .MAX_POS(10)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Raise a request and return #1 after the edge where move_ack is visible (cycle T).
  task automatic start(input logic player, input logic [3:0] target);
    bit got = 0;
    bus.move_player = player;
    bus.move_target = target;
    bus.move_req    = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.move_ack === 1'b1) got = 1;
    end
    bus.move_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: no move_ack for player %0d target %0d", player, target);
    end
  endtask

  // Record outputs for cycles T..T+len; index 0 is the ack cycle.
  task automatic watch(input int len);
    for (int k = 0; k <= len; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      p1_h[k] = bus.p1_disp;
      p2_h[k] = bus.p2_disp;
      sp_h[k] = bus.step_pulse;
      td_h[k] = bus.turn_done;
      bz_h[k] = bus.busy;
      ak_h[k] = bus.move_ack;
      if (k > 0 && bus.move_ack === 1'b1) bus.move_req = 1'b0;
      bus.game_clear = (k == clear_at);
    end
    bus.game_clear = 1'b0;
  endtask

  function automatic int count_sp(input int len);
    int n = 0;
    for (int k = 0; k <= len; k++) if (sp_h[k] === 1'b1) n++;
    return n;
  endfunction

  function automatic int first_td(input int len);
    for (int k = 0; k <= len; k++) if (td_h[k] === 1'b1) return k;
    return -1;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.p1_disp, bus.p2_disp, bus.move_ack, bus.busy, bus.step_pulse, bus.turn_done} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got p1=%0d p2=%0d ack=%b busy=%b sp=%b td=%b, want all 0",
               bus.p1_disp, bus.p2_disp, bus.move_ack, bus.busy, bus.step_pulse, bus.turn_done);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_up_move;
    int bad_p2 = 0;
    start(1'b0, 4'd3);
    watch(20);
    checks++;
    if (bz_h[0] !== 1'b0 || bz_h[1] !== 1'b1) begin
      errors++; $display("FAIL up_busy: got T=%b T+1=%b, want 0 1", bz_h[0], bz_h[1]);
    end
    checks++;
    if ({p1_h[3], p1_h[4], p1_h[8], p1_h[12]} !== {4'd0, 4'd1, 4'd2, 4'd3}) begin
      errors++; $display("FAIL up_disp: got %0d %0d %0d %0d, want 0 1 2 3", p1_h[3], p1_h[4], p1_h[8], p1_h[12]);
    end
    checks++;
    if (count_sp(20) != 3 || sp_h[4] !== 1'b1 || sp_h[12] !== 1'b1) begin
      errors++; $display("FAIL up_steps: got %0d pulses, want 3 at T+4/8/12", count_sp(20));
    end
    checks++;
    if (first_td(20) != 16 || td_h[17] !== 1'b0) begin
      errors++; $display("FAIL up_done: got first turn_done at T+%0d, want T+16 single", first_td(20));
    end
    for (int k = 0; k <= 20; k++) if (p2_h[k] !== 4'd0) bad_p2++;
    checks++;
    if (bad_p2 != 0) begin
      errors++; $display("FAIL up_other_player: p2 moved in %0d cycles, want 0", bad_p2);
    end
  endtask

  task automatic test_down_move;
    start(1'b0, 4'd0);
    watch(20);
`ifdef ANIM_BACKJUMP_EN
    checks++;
    if (p1_h[3] !== 4'd3 || p1_h[4] !== 4'd0) begin
      errors++; $display("FAIL down_disp: got %0d %0d, want 3 0", p1_h[3], p1_h[4]);
    end
    checks++;
    if (count_sp(20) != 1 || first_td(20) != 8) begin
      errors++; $display("FAIL down_done: got %0d pulses, turn_done T+%0d, want 1 and T+8", count_sp(20), first_td(20));
    end
`else
    checks++;
    if ({p1_h[4], p1_h[8], p1_h[12]} !== {4'd2, 4'd1, 4'd0}) begin
      errors++; $display("FAIL down_disp: got %0d %0d %0d, want 2 1 0", p1_h[4], p1_h[8], p1_h[12]);
    end
    checks++;
    if (count_sp(20) != 3 || first_td(20) != 16) begin
      errors++; $display("FAIL down_done: got %0d pulses, turn_done T+%0d, want 3 and T+16", count_sp(20), first_td(20));
    end
`endif
  endtask

  task automatic test_clamp;
    start(1'b1, 4'd9);
    watch(45);
    checks++;
    if (p2_h[45] !== 4'd9) begin
      errors++; $display("FAIL clamp_setup: got p2=%0d, want 9", p2_h[45]);
    end
    start(1'b1, 4'd13);
    watch(12);
    checks++;
    if (p2_h[4] !== 4'd10 || p2_h[12] !== 4'd10 || p1_h[12] !== 4'd0) begin
      errors++; $display("FAIL clamp_disp: got p2=%0d/%0d p1=%0d, want 10/10 0", p2_h[4], p2_h[12], p1_h[12]);
    end
    checks++;
    if (count_sp(12) != 1 || first_td(12) != 8) begin
      errors++; $display("FAIL clamp_done: got %0d pulses, turn_done T+%0d, want 1 and T+8", count_sp(12), first_td(12));
    end
  endtask

  task automatic test_zero_distance;
    start(1'b0, 4'd5);
    watch(25);
    start(1'b0, 4'd5);
    watch(10);
    checks++;
    if (count_sp(10) != 0 || first_td(10) != 4 || p1_h[10] !== 4'd5) begin
      errors++; $display("FAIL zero_dist: got %0d pulses, turn_done T+%0d, p1=%0d, want 0, T+4, 5",
                         count_sp(10), first_td(10), p1_h[10]);
    end
  endtask

  task automatic test_back_to_back;
    int early = 0;
    start(1'b0, 4'd7);
    bus.move_player = 1'b1;
    bus.move_target = 4'd9;
    bus.move_req    = 1'b1;
    watch(30);
    for (int k = 1; k <= 12; k++) if (ak_h[k] === 1'b1) early++;
    checks++;
    if (early != 0 || first_td(30) != 12) begin
      errors++; $display("FAIL b2b_busy: got %0d acks while busy, turn_done T+%0d, want 0 and T+12", early, first_td(30));
    end
    checks++;
    if (ak_h[13] !== 1'b1) begin
      errors++; $display("FAIL b2b_ack: got ack=%b at T+13, want 1", ak_h[13]);
    end
    checks++;
    if (p2_h[16] !== 4'd10 || p2_h[17] !== 4'd9 || td_h[21] !== 1'b1 || p1_h[30] !== 4'd7) begin
      errors++; $display("FAIL b2b_second: got p2=%0d,%0d td=%b p1=%0d, want 10,9 1 7",
                         p2_h[16], p2_h[17], td_h[21], p1_h[30]);
    end
  endtask

  task automatic test_clear;
    start(1'b0, 4'd10);
    clear_at = 6;
    watch(25);
    clear_at = -1;
    checks++;
    if (p1_h[4] !== 4'd8 || p1_h[7] !== 4'd0 || p2_h[7] !== 4'd0 || bz_h[6] !== 1'b1 || bz_h[7] !== 1'b0) begin
      errors++; $display("FAIL clear_state: got p1=%0d,%0d p2=%0d busy=%b,%b, want 8,0 0 1,0",
                         p1_h[4], p1_h[7], p2_h[7], bz_h[6], bz_h[7]);
    end
    checks++;
    if (first_td(25) != -1 || count_sp(25) != 1) begin
      errors++; $display("FAIL clear_no_done: got turn_done T+%0d, %0d pulses, want none and 1", first_td(25), count_sp(25));
    end
  endtask

  task automatic test_reset_mid_move;
    start(1'b1, 4'd3);
    watch(5);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    watch(20);
    checks++;
    if (p2_h[0] !== 4'd0 || bz_h[0] !== 1'b0 || first_td(20) != -1 || count_sp(20) != 0) begin
      errors++; $display("FAIL reset_mid: got p2=%0d busy=%b td_at=%0d pulses=%0d, want 0 0 -1 0",
                         p2_h[0], bz_h[0], first_td(20), count_sp(20));
    end
  endtask

  initial begin
    bus.game_clear  = 1'b0;
    bus.move_req    = 1'b0;
    bus.move_player = 1'b0;
    bus.move_target = 4'd0;
    test_reset;
    test_up_move;
    test_down_move;
    test_clamp;
    test_zero_distance;
    test_back_to_back;
    test_clear;
    test_reset_mid_move;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
